// File: rtl/i2s_clk_ctrl.sv
// rtl/i2s_clk_ctrl.sv - I2S BCLK/LRCLK generator with frame-aligned run/stop and rate changes
module i2s_clk_ctrl #(
  parameter int DIV_W    = 4,
  parameter int SLOT_W   = 6,
  parameter int DEF_HALF = 1,
  parameter int DEF_SLOT = 31
) (
  input  logic              MCLK,
  input  logic              MRST,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_bclk_half,
  input  logic [SLOT_W-1:0] cfg_slot_bits,
  output logic              BCLK,
  output logic              LRCLK,
  output logic              bclk_rise_stb,
  output logic              bclk_fall_stb,
  output logic              frame_stb,
  output logic              running
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t            state;
  logic [DIV_W-1:0]  half_q, pend_half, div_cnt;
  logic [SLOT_W-1:0] slot_q, pend_slot, bit_cnt;
  logic              pend_valid;

  logic              xfer;
  logic [SLOT_W-1:0] slot_clamped;
  logic              div_wrap, fall_edge, slot_end, frame_end;

  assign cfg_ready    = (state == IDLE) || !pend_valid;
  assign xfer         = cfg_valid && cfg_ready;
  assign slot_clamped = (cfg_slot_bits == '0) ? SLOT_W'(1) : cfg_slot_bits;
  assign running      = (state != IDLE);

  // A frame ends on the falling BCLK edge that closes the right slot.
  assign div_wrap  = (div_cnt == half_q);
  assign fall_edge = div_wrap && BCLK;
  assign slot_end  = fall_edge && (bit_cnt == slot_q);
  assign frame_end = slot_end && LRCLK;

  always_ff @(posedge MCLK) begin
    if (MRST) begin
      state         <= IDLE;
      half_q        <= DIV_W'(DEF_HALF);
      slot_q        <= SLOT_W'(DEF_SLOT);
      pend_half     <= '0;
      pend_slot     <= '0;
      pend_valid    <= 1'b0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      BCLK          <= 1'b0;
      LRCLK         <= 1'b0;
      bclk_rise_stb <= 1'b0;
      bclk_fall_stb <= 1'b0;
      frame_stb     <= 1'b0;
    end else begin
      bclk_rise_stb <= 1'b0;
      bclk_fall_stb <= 1'b0;
      frame_stb     <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt    <= '0;
          bit_cnt    <= '0;
          BCLK       <= 1'b0;
          LRCLK      <= 1'b0;
          pend_valid <= 1'b0;
          if (xfer) begin
            half_q <= cfg_bclk_half;
            slot_q <= slot_clamped;
          end else if (pend_valid) begin
            half_q <= pend_half;
            slot_q <= pend_slot;
          end
          if (en) begin
            state     <= RUN;
            frame_stb <= 1'b1;
          end
        end
        default: begin
          state <= en ? RUN : STOPPING;
          if (div_wrap) begin
            div_cnt       <= '0;
            BCLK          <= ~BCLK;
            bclk_rise_stb <= ~BCLK;
            bclk_fall_stb <= BCLK;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
          if (fall_edge) begin
            if (slot_end) begin
              bit_cnt <= '0;
              LRCLK   <= ~LRCLK;
            end else begin
              bit_cnt <= bit_cnt + SLOT_W'(1);
            end
          end
          if (frame_end) begin
            if (pend_valid) begin
              half_q     <= pend_half;
              slot_q     <= pend_slot;
              pend_valid <= 1'b0;
            end
            if (state == STOPPING && !en) state <= IDLE;
            else frame_stb <= 1'b1;
          end
          // Offered on a boundary edge, a config still waits for the following frame.
          if (xfer) begin
            pend_half  <= cfg_bclk_half;
            pend_slot  <= slot_clamped;
            pend_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// tb/tb_i2s_clk_ctrl.sv - self-checking bench for i2s_clk_ctrl against a frame-phase reference model
module tb_i2s_clk_ctrl;

  logic       MCLK = 1'b0;
  logic       MRST = 1'b1;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_bclk_half = '0;
  logic [5:0] cfg_slot_bits = '0;
  logic       BCLK, LRCLK, bclk_rise_stb, bclk_fall_stb, frame_stb, running;

  i2s_clk_ctrl dut (
    .MCLK(MCLK), .MRST(MRST), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_bclk_half(cfg_bclk_half), .cfg_slot_bits(cfg_slot_bits),
    .BCLK(BCLK), .LRCLK(LRCLK), .bclk_rise_stb(bclk_rise_stb), .bclk_fall_stb(bclk_fall_stb),
    .frame_stb(frame_stb), .running(running)
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fq[$];
  int rq[$];

  // Reference model: position t within the current frame plus active/pending rates.
  int m_state = 0;  // 0 idle, 1 run, 2 stopping
  int m_t = 0, m_h = 1, m_s = 31, m_ph = 0, m_ps = 0;
  bit m_pv = 0, m_first = 0, m_stopfall = 0;

  function automatic int clamp_slot(int s);
    return (s == 0) ? 1 : s;
  endfunction

  task automatic model_step();
    bit ready, xfer;
    int flen;
    m_stopfall = 0;
    if (MRST) begin
      m_state = 0; m_h = 1; m_s = 31; m_pv = 0; m_t = 0; m_first = 0;
      return;
    end
    ready = (m_state == 0) || !m_pv;
    xfer  = cfg_valid && ready;
    if (m_state == 0) begin
      if (xfer) begin m_h = cfg_bclk_half; m_s = clamp_slot(cfg_slot_bits); end
      else if (m_pv) begin m_h = m_ph; m_s = m_ps; end
      m_pv = 0;
      if (en) begin m_state = 1; m_t = 0; m_first = 1; end
    end else begin
      flen = 4 * (m_s + 1) * (m_h + 1);
      if (m_t == flen - 1) begin
        if (m_pv) begin m_h = m_ph; m_s = m_ps; m_pv = 0; end
        if (m_state == 2 && !en) begin m_state = 0; m_stopfall = 1; m_t = 0; end
        else begin m_state = en ? 1 : 2; m_t = 0; m_first = 0; end
      end else begin
        m_t++;
        m_state = en ? 1 : 2;
      end
      if (xfer) begin m_ph = cfg_bclk_half; m_ps = clamp_slot(cfg_slot_bits); m_pv = 1; end
    end
  endtask

  function automatic logic [6:0] model_vec();
    int hp, q, r;
    logic b, l, ri, fa, fr;
    if (m_state == 0) return {3'b000, m_stopfall, 3'b001};
    hp = m_h + 1;
    q  = m_t / hp;
    r  = m_t % hp;
    b  = (q % 2) == 1;
    l  = ((m_t / ((m_s + 1) * 2 * hp)) % 2) == 1;
    ri = (r == 0) && (q % 2 == 1);
    fa = (r == 0) && (q % 2 == 0) && (m_t > 0 || !m_first);
    fr = (m_t == 0);
    return {b, l, ri, fa, fr, 1'b1, !m_pv};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {BCLK, LRCLK, bclk_rise_stb, bclk_fall_stb, frame_stb, running, cfg_ready};
  endfunction

  task automatic tick();
    @(posedge MCLK);
    model_step();
    cyc++;
    @(negedge MCLK);
    if (frame_stb === 1'b1) fq.push_back(cyc);
    if (bclk_rise_stb === 1'b1) rq.push_back(cyc);
  endtask

  task automatic test_reset();
    MRST = 1; en = 0; cfg_valid = 0;
    tick(); tick();
    checks++;
    if (dut_vec() !== 7'b0000001) begin
      errors++; $display("FAIL reset_state got %b expected %b", dut_vec(), 7'b0000001);
    end
    MRST = 0;
  endtask

  task automatic test_defaults();
    fq.delete(); rq.delete();
    en = 1;
    for (int i = 0; i < 600; i++) begin
      tick(); checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL defaults_lockstep cyc %0d got %b expected %b", cyc, dut_vec(), model_vec());
      end
    end
    checks++;
    if (fq.size() != 3) begin errors++; $display("FAIL defaults_frame_count got %0d expected 3", fq.size()); end
    for (int i = 1; i < fq.size(); i++) begin
      checks++;
      if (fq[i] - fq[i-1] != 256) begin errors++; $display("FAIL defaults_frame_period got %0d expected 256", fq[i] - fq[i-1]); end
    end
    for (int i = 1; i < rq.size(); i++) begin
      checks++;
      if (rq[i] - rq[i-1] != 4) begin errors++; $display("FAIL defaults_bclk_period got %0d expected 4", rq[i] - rq[i-1]); end
    end
  endtask

  task automatic test_idle_cfg();
    MRST = 1; en = 0; tick(); MRST = 0;
    fq.delete(); rq.delete();
    cfg_valid = 1; cfg_bclk_half = 4'd3; cfg_slot_bits = 6'd15; en = 1;
    for (int i = 0; i < 600; i++) begin
      tick(); cfg_valid = 0; checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL idle_cfg_lockstep cyc %0d got %b expected %b", cyc, dut_vec(), model_vec());
      end
    end
    for (int i = 1; i < fq.size(); i++) begin
      checks++;
      if (fq[i] - fq[i-1] != 256) begin errors++; $display("FAIL idle_cfg_frame_period got %0d expected 256", fq[i] - fq[i-1]); end
    end
    for (int i = 1; i < rq.size(); i++) begin
      checks++;
      if (rq[i] - rq[i-1] != 8) begin errors++; $display("FAIL idle_cfg_bclk_period got %0d expected 8", rq[i] - rq[i-1]); end
    end
  endtask

  task automatic test_run_cfg();
    MRST = 1; en = 0; tick(); MRST = 0;
    fq.delete();
    en = 1;
    for (int i = 0; i < 100; i++) begin
      tick(); checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL run_cfg_lockstep cyc %0d got %b expected %b", cyc, dut_vec(), model_vec());
      end
    end
    cfg_valid = 1; cfg_bclk_half = 4'd0; cfg_slot_bits = 6'd31;
    tick(); cfg_valid = 0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL run_cfg_ready got %b expected 0", cfg_ready); end
    for (int i = 0; i < 600; i++) begin
      tick(); checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL run_cfg_lockstep cyc %0d got %b expected %b", cyc, dut_vec(), model_vec());
      end
    end
    checks++;
    if (fq.size() < 4) begin errors++; $display("FAIL run_cfg_frame_count got %0d expected at least 4", fq.size()); end
    else begin
      checks++;
      if (fq[1] - fq[0] != 256) begin errors++; $display("FAIL run_cfg_old_period got %0d expected 256", fq[1] - fq[0]); end
      for (int i = 2; i < fq.size(); i++) begin
        checks++;
        if (fq[i] - fq[i-1] != 128) begin errors++; $display("FAIL run_cfg_new_period got %0d expected 128", fq[i] - fq[i-1]); end
      end
    end
  endtask

  task automatic test_stop();
    int fstart, idle_at;
    MRST = 1; en = 0; tick(); MRST = 0;
    en = 1;
    for (int i = 0; i < 300 && !(m_state != 0 && m_t == 150); i++) begin
      tick(); checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL stop_lockstep cyc %0d got %b expected %b", cyc, dut_vec(), model_vec());
      end
    end
    fstart = cyc - 150;
    en = 0;
    idle_at = -1;
    for (int i = 0; i < 400 && idle_at < 0; i++) begin
      tick(); checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL stop_lockstep cyc %0d got %b expected %b", cyc, dut_vec(), model_vec());
      end
      if (running === 1'b0) idle_at = cyc;
    end
    checks++;
    if (idle_at - fstart != 256) begin errors++; $display("FAIL stop_at_boundary got %0d expected 256", idle_at - fstart); end
    tick(); checks++;
    if (dut_vec() !== 7'b0000001) begin errors++; $display("FAIL stop_idle_outputs got %b expected %b", dut_vec(), 7'b0000001); end
  endtask

  task automatic test_stop_resume();
    fq.delete();
    en = 1;
    for (int i = 0; i < 450; i++) begin
      tick(); checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL resume_lockstep cyc %0d got %b expected %b", cyc, dut_vec(), model_vec());
      end
      if (i == 150) en = 0;
      if (i == 230) en = 1;
    end
    checks++;
    if (fq.size() != 2) begin errors++; $display("FAIL resume_frame_count got %0d expected 2", fq.size()); end
    for (int i = 1; i < fq.size(); i++) begin
      checks++;
      if (fq[i] - fq[i-1] != 256) begin errors++; $display("FAIL resume_frame_period got %0d expected 256", fq[i] - fq[i-1]); end
    end
  endtask

  task automatic test_reset_pending();
    for (int i = 0; i < 70; i++) tick();
    cfg_valid = 1; cfg_bclk_half = 4'd0; cfg_slot_bits = 6'd3;
    tick(); cfg_valid = 0;
    tick();
    MRST = 1; tick(); MRST = 0;
    checks++;
    if (dut_vec() !== 7'b0000001) begin errors++; $display("FAIL reset_pending_outputs got %b expected %b", dut_vec(), 7'b0000001); end
    fq.delete();
    en = 1;
    for (int i = 0; i < 600; i++) begin
      tick(); checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL reset_pending_lockstep cyc %0d got %b expected %b", cyc, dut_vec(), model_vec());
      end
    end
    for (int i = 1; i < fq.size(); i++) begin
      checks++;
      if (fq[i] - fq[i-1] != 256) begin errors++; $display("FAIL reset_pending_period got %0d expected 256", fq[i] - fq[i-1]); end
    end
  endtask

  task automatic test_min_rate();
    MRST = 1; en = 0; tick(); MRST = 0;
    fq.delete(); rq.delete();
    cfg_valid = 1; cfg_bclk_half = 4'd0; cfg_slot_bits = 6'd0; en = 1;
    for (int i = 0; i < 100; i++) begin
      tick(); cfg_valid = 0; checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL min_rate_lockstep cyc %0d got %b expected %b", cyc, dut_vec(), model_vec());
      end
    end
    for (int i = 1; i < fq.size(); i++) begin
      checks++;
      if (fq[i] - fq[i-1] != 8) begin errors++; $display("FAIL min_rate_frame_period got %0d expected 8", fq[i] - fq[i-1]); end
    end
    for (int i = 1; i < rq.size(); i++) begin
      checks++;
      if (rq[i] - rq[i-1] != 2) begin errors++; $display("FAIL min_rate_bclk_period got %0d expected 2", rq[i] - rq[i-1]); end
    end
  endtask

  task automatic test_random();
    MRST = 1; tick(); MRST = 0;
    en = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 31) == 0) en = ~en;
      cfg_valid     = ($urandom_range(0, 15) == 0);
      cfg_bclk_half = 4'($urandom_range(0, 2));
      cfg_slot_bits = 6'($urandom_range(0, 7));
      MRST          = ($urandom_range(0, 499) == 0);
      tick(); checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random_lockstep cyc %0d got %b expected %b", cyc, dut_vec(), model_vec());
      end
    end
    MRST = 0; cfg_valid = 0;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_idle_cfg();
    test_run_cfg();
    test_stop();
    test_stop_resume();
    test_reset_pending();
    test_min_rate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
